// File: rtl/matmul_addr_gen.sv
// Address sequencer for an NxN matrix multiply: one A address and LANES B
// addresses per beat, plus the C write address on the last beat of each dot product.
module matmul_addr_gen #(
    parameter int N     = 8,
    parameter int LANES = 2,
    parameter int AW    = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                a_trans_i,
    input  logic [AW-1:0]       base_a_i,
    input  logic [AW-1:0]       base_b_i,
    input  logic [AW-1:0]       base_c_i,
    input  logic                addr_ready_i,
    output logic                addr_valid_o,
    output logic [AW-1:0]       addr_a_o,
    output logic [LANES*AW-1:0] addr_b_o,
    output logic [AW-1:0]       addr_c_o,
    output logic                k_first_o,
    output logic                k_last_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int LG = (N > 1) ? $clog2(N) : 1;
    localparam logic [LG-1:0] KMAX  = LG'(N - 1);
    localparam logic [LG-1:0] JMAX  = LG'(N - LANES);
    // When LANES == N this truncates to 0, so j stays at 0 as intended.
    localparam logic [LG-1:0] JSTEP = LG'(LANES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [LG-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [AW-1:0]   base_a_q, base_b_q, base_c_q;
    logic            trans_q;
    logic            load, clr, hs, last;
    logic [AW-1:0]   a_addr, c_addr;
    logic [LANES-1:0][AW-1:0] b_lane;

    assign load = (state_q == IDLE) && start_i;
    assign clr  = load || ((state_q == RUN) && abort_i);
    assign hs   = (state_q == RUN) && addr_ready_i;
    assign last = (i_q == KMAX) && (j_q == JMAX) && (k_q == KMAX);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN: begin
                if (abort_i)         state_d = IDLE;
                else if (hs && last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Loop nest: k innermost, then j in LANES-wide steps, then i.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (hs) begin
            k_d = k_q + LG'(1);
            if (k_q == KMAX) begin
                j_d = j_q + JSTEP;
                if (j_q == JMAX) begin
                    j_d = '0;
                    i_d = i_q + LG'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            trans_q  <= 1'b0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
            if (load) begin
                base_a_q <= base_a_i;
                base_b_q <= base_b_i;
                base_c_q <= base_c_i;
                trans_q  <= a_trans_i;
            end
        end
    end

    // N is a power of two, so row*N+col is just {row, col}.
    assign a_addr = base_a_q + (trans_q ? AW'({i_q, k_q}) : AW'({k_q, i_q}));
    assign c_addr = base_c_q + AW'({i_q, j_q});

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LG-1:0] col;
        assign col       = j_q + LG'(l);
        assign b_lane[l] = base_b_q + AW'({col, k_q});
    end

    always_comb begin
        addr_valid_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        addr_a_o     = '0;
        addr_b_o     = '0;
        addr_c_o     = '0;
        k_first_o    = 1'b0;
        k_last_o     = 1'b0;
        case (state_q)
            RUN: begin
                addr_valid_o = 1'b1;
                busy_o       = 1'b1;
                addr_a_o     = a_addr;
                addr_b_o     = b_lane;
                addr_c_o     = c_addr;
                k_first_o    = (k_q == '0);
                k_last_o     = (k_q == KMAX);
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matmul_addr_gen.sv
// Scoreboard bench for matmul_addr_gen: expected beats come from a loop-nest
// model of the matrix walk; monitors pop and compare on every handshake.
module tb_matmul_addr_gen;
    localparam int N = 8, L = 2, N4 = 4, L4 = 4, AW = 8, BW = 4 * AW;
    localparam int NB  = N * N * N / L;
    localparam int NB4 = N4 * N4 * N4 / L4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [AW-1:0] c;
        logic          kf;
        logic          kl;
    } beat_t;

    logic clk = 0, reset = 1, start = 0, start4 = 0, abort = 0, a_trans = 0, ready = 0;
    logic [AW-1:0] base_a = 0, base_b = 0, base_c = 0;
    logic valid, busy, done, kf, kl;
    logic [AW-1:0] aa, ac;
    logic [L*AW-1:0] ab;
    logic valid4, busy4, done4, kf4, kl4;
    logic [AW-1:0] aa4, ac4;
    logic [L4*AW-1:0] ab4;

    int checks = 0, errors = 0, cyc = 0;
    int hs_cnt = 0, last_hs = -10, done_cnt = 0, hs4 = 0, done4_cnt = 0;
    bit done_allowed = 0, stall_q = 0;
    beat_t held, first4;
    beat_t q[$];
    beat_t q4[$];
    beat_t seen[NB];

    matmul_addr_gen #(.N(N), .LANES(L), .AW(AW)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort), .a_trans_i(a_trans),
        .base_a_i(base_a), .base_b_i(base_b), .base_c_i(base_c), .addr_ready_i(ready),
        .addr_valid_o(valid), .addr_a_o(aa), .addr_b_o(ab), .addr_c_o(ac),
        .k_first_o(kf), .k_last_o(kl), .busy_o(busy), .done_o(done));

    matmul_addr_gen #(.N(N4), .LANES(L4), .AW(AW)) dut4 (
        .clk_i(clk), .reset_i(reset), .start_i(start4), .abort_i(abort), .a_trans_i(a_trans),
        .base_a_i(base_a), .base_b_i(base_b), .base_c_i(base_c), .addr_ready_i(ready),
        .addr_valid_o(valid4), .addr_a_o(aa4), .addr_b_o(ab4), .addr_c_o(ac4),
        .k_first_o(kf4), .k_last_o(kl4), .busy_o(busy4), .done_o(done4));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Beat n of the walk C = A x B for an nn x nn matrix with ll lanes.
    function automatic beat_t model(int n, int nn, int ll, logic [AW-1:0] ba, logic [AW-1:0] bb,
                                    logic [AW-1:0] bc, bit tr);
        beat_t e;
        int k, t, jb, j, i;
        k  = n % nn;
        t  = n / nn;
        jb = nn / ll;
        j  = (t % jb) * ll;
        i  = t / jb;
        e    = '0;
        e.a  = ba + AW'(tr ? i * nn + k : k * nn + i);
        for (int l = 0; l < ll; l++) e.b[l*AW +: AW] = bb + AW'((j + l) * nn + k);
        e.c  = bc + AW'(i * nn + j);
        e.kf = (k == 0);
        e.kl = (k == nn - 1);
        return e;
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor for the N=8 instance.
    initial forever begin
        beat_t g, e;
        @(negedge clk);
        g.a = aa; g.b = BW'(ab); g.c = ac; g.kf = kf; g.kl = kl;
        if (!valid) begin
            checks++;
            if (g != '0 || busy) begin
                errors++;
                $display("FAIL idle_outputs: got %h busy %b expected all zero", g, busy);
            end
        end else begin
            if (stall_q) begin
                checks++;
                if (g !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got %h expected %h", g, held);
                end
            end
            if (ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got %h expected no beat", g);
                end else begin
                    e = q.pop_front();
                    if (g !== e || !busy) begin
                        errors++;
                        $display("FAIL beat%0d: got %h busy %b expected %h busy 1", hs_cnt, g, busy, e);
                    end
                end
                if (hs_cnt < NB) seen[hs_cnt] = g;
                hs_cnt++;
                last_hs = cyc;
            end
        end
        stall_q = valid && !ready;
        held = g;
        if (done) begin
            checks++;
            if (!done_allowed || q.size() != 0 || cyc != last_hs + 1 || busy) begin
                errors++;
                $display("FAIL done_pulse: got done at cycle %0d (left %0d, allowed %0b) expected cycle %0d",
                         cyc, q.size(), done_allowed, last_hs + 1);
            end
            done_cnt++;
        end
    end

    // Monitor for the LANES==N instance.
    initial forever begin
        beat_t g, e;
        @(negedge clk);
        g.a = aa4; g.b = BW'(ab4); g.c = ac4; g.kf = kf4; g.kl = kl4;
        if (!valid4) begin
            checks++;
            if (g != '0 || busy4) begin
                errors++;
                $display("FAIL idle_outputs4: got %h busy %b expected all zero", g, busy4);
            end
        end else if (ready) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL extra_beat4: got %h expected no beat", g);
            end else begin
                e = q4.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL beat4_%0d: got %h expected %h", hs4, g, e);
                end
            end
            if (hs4 == 0) first4 = g;
            hs4++;
        end
        if (done4) begin
            checks++;
            if (q4.size() != 0 || busy4) begin
                errors++;
                $display("FAIL done4: got done with %0d beats left expected 0", q4.size());
            end
            done4_cnt++;
        end
    end

    task automatic run(bit tr, logic [AW-1:0] ba, logic [AW-1:0] bb, logic [AW-1:0] bc,
                       bit rr, int abort_at, int reset_at, int mid_at);
        int budget;
        bit fin;
        budget = 0;
        fin    = 0;
        for (int n = 0; n < NB; n++) q.push_back(model(n, N, L, ba, bb, bc, tr));
        hs_cnt = 0; done_cnt = 0; last_hs = -10;
        done_allowed = (abort_at < 0) && (reset_at < 0);
        a_trans = tr; base_a = ba; base_b = bb; base_c = bc;
        start = 1; ready = 1;
        @(posedge clk); #1;
        start = 0;
        // Scramble inputs: the run must keep using the values latched at start.
        a_trans = ~tr; base_a = AW'($urandom); base_b = AW'($urandom); base_c = AW'($urandom);
        chk("first_beat_latency", valid, 1);
        while (!fin) begin
            ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hs_cnt == abort_at) begin
                abort = 1; ready = 0;
                @(posedge clk); #1;
                abort = 0;
                chk("abort_busy", busy, 0);
                chk("abort_valid", valid, 0);
                fin = 1;
            end else if (hs_cnt == reset_at) begin
                reset = 1; #1;
                chk("midrun_reset_valid", valid, 0);
                chk("midrun_reset_busy", busy, 0);
                chk("midrun_reset_addr", {aa, ab, ac, kf, kl}, 0);
                @(posedge clk); #1;
                reset = 0;
                fin = 1;
            end else begin
                if (hs_cnt == mid_at) start = 1;
                @(posedge clk); #1;
                start = 0;
                budget++;
                if (done_cnt > 0) fin = 1;
                else if (budget > 4 * NB + 20) begin
                    checks++; errors++;
                    $display("FAIL run_timeout: got %0d beats expected %0d", hs_cnt, NB);
                    fin = 1;
                end
            end
        end
        if (abort_at >= 0 || reset_at >= 0) begin
            ready = 1;
            repeat (3) @(posedge clk);
            #1;
            chk("no_done_after_stop", done_cnt, 0);
            q.delete();
        end else begin
            chk("handshake_count", hs_cnt, NB);
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
        end
        done_allowed = 0;
    endtask

    task automatic run4();
        int budget;
        budget = 0;
        for (int n = 0; n < NB4; n++) q4.push_back(model(n, N4, L4, 0, 0, 0, 0));
        hs4 = 0; done4_cnt = 0;
        a_trans = 0; base_a = 0; base_b = 0; base_c = 0;
        ready = 1; start4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        while (done4_cnt == 0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("lanesN_done", done4_cnt, 1);
        chk("lanesN_beats", hs4, NB4);
        chk("lanesN_beat0_b", first4.b, 32'h0C080400);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_addr", {aa, ab, ac, kf, kl}, 0);
        reset = 0;
        @(posedge clk); #1;

        run(0, 0, 0, 0, 0, -1, -1, -1);
        chk("b0_a", seen[0].a, 0);
        chk("b0_b", seen[0].b[15:0], 16'h0800);
        chk("b0_kfirst", seen[0].kf, 1);
        chk("b1_a", seen[1].a, 8);
        chk("b1_b", seen[1].b[15:0], 16'h0901);
        chk("b7_a", seen[7].a, 56);
        chk("b7_b", seen[7].b[15:0], 16'h0F07);
        chk("b7_klast", seen[7].kl, 1);
        chk("b7_c", seen[7].c, 0);
        chk("b8_b", seen[8].b[15:0], 16'h1810);
        chk("b8_c", seen[8].c, 2);

        run(1, 0, 0, 0, 0, -1, -1, -1);
        chk("trans_b1_a", seen[1].a, 1);
        chk("trans_b8_a", seen[8].a, 0);
        chk("trans_b32_a", seen[32].a, 8);

        run(0, AW'($urandom), AW'($urandom), AW'($urandom), 1, -1, -1, 50);

        run(0, 3, 250, 200, 0, -1, -1, -1);
        chk("wrap_b_lane0", seen[0].b[7:0], 250);
        chk("wrap_b_lane1", seen[0].b[15:8], 2);

        run(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), AW'($urandom), 0, 100, -1, -1);
        run(0, 0, 0, 0, 1, -1, -1, -1);
        run(1, AW'($urandom), AW'($urandom), AW'($urandom), 1, -1, 60, -1);
        run(1, AW'($urandom), AW'($urandom), AW'($urandom), 1, -1, -1, -1);
        run4();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
